mod_mul_arbiter: RTL
====================

# mod_mul_arbiter

Round-robin arbiter and sequencer that shares one Montgomery modular multiplier (`mod_mul_il`) between up to `NREQ` requesters. Typical requesters are conv-to-Montgomery, the exponentiation ladder, and Montgomery-to-conv. It latches the winning requester's operands, issues a one-cycle start pulse, waits for the multiplier's done pulse, and returns the registered result with a per-requester done pulse. A watchdog aborts any operation the multiplier never completes.

## Interface
Parameters:
- `NBITS`, default 256: operand/result width.
- `NREQ`, default 3: number of requesters, 2 to 8.
- `TIMEOUT`, default 4096: maximum cycles spent in WAIT before abort; must be ≥ 2.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high. The top level drives the multiplier's `rst_n` from `~rst`.
- `req`  in  NREQ: level request per requester; held high until that requester's `done_p` or `err_p`.
- `req_a`  in  NREQ*NBITS: operand A; requester i occupies bits [i*NBITS +: NBITS].
- `req_b`  in  NREQ*NBITS: operand B, same packing as `req_a`.
- `req_m`  in  NREQ*NBITS: modulus, same packing as `req_a`.
- `gnt`  out  NREQ: one-hot owner of the multiplier; all-zero when idle.
- `done_p`  out  NREQ: one-cycle completion pulse to the owner.
- `err_p`  out  NREQ: one-cycle timeout pulse to the owner.
- `y`  out  NBITS: registered result; holds until the next completion.
- `busy`  out  1: high in any state other than IDLE.
- `mm_enable_p`  out  1: start pulse to the multiplier.
- `mm_a`, `mm_b`, `mm_m`  out  NBITS each: latched operands to the multiplier.
- `mm_y`  in  NBITS: multiplier result.
- `mm_done_irq_p`  in  1: multiplier done pulse.

## Operation
FSM states: IDLE, ISSUE, WAIT, DONE.

- **IDLE**
  - If `req != 0`: select the winner by round-robin, starting the search at `ptr` and moving upward with wrap-around.
  - Latch the winner's A/B/M into `mm_a`/`mm_b`/`mm_m`, set `gnt[winner]`, record the index in `own`, and go to ISSUE.
  - Otherwise remain in IDLE.
- **ISSUE**: `mm_enable_p = 1` for this cycle only; clear the watchdog counter; go to WAIT.
- **WAIT**
  - On `mm_done_irq_p`: capture `mm_y` into `y` and go to DONE.
  - Else if the counter reaches `TIMEOUT-1`: assert `err_p[own]` for one cycle, clear `gnt`, set `ptr = own+1 mod NREQ`, and go to IDLE. `y` is left unchanged.
  - Otherwise increment the counter.
- **DONE**: assert `done_p[own]` for one cycle, clear `gnt`, set `ptr = own+1 mod NREQ`, and go to IDLE.

Rules and boundary conditions:
- `mm_a`, `mm_b` and `mm_m` are stable from ISSUE through DONE. Later changes on `req_*` do not affect an operation in flight.
- A `mm_done_irq_p` arriving in IDLE, ISSUE or DONE is ignored.
- If the owner drops `req` mid-operation, the operation still completes and `done_p` still pulses.
- A `req` that is still high in the IDLE cycle after `done_p` counts as a new request. Requesters drop `req` on the edge where they see `done_p`.
- Simultaneous requests are granted in ptr-first round-robin order. No requester waits more than `NREQ-1` operations.
- When `ptr` wraps past `NREQ-1`, it returns to 0.

## Timing
Reset values (asynchronous, applied immediately):
- state = IDLE, `ptr` = 0, `own` = 0, counter = 0.
- `gnt`, `done_p`, `err_p` = 0; `busy` = 0; `mm_enable_p` = 0.
- `y`, `mm_a`, `mm_b`, `mm_m` = 0.

Reset mid-operation aborts without any `done_p` or `err_p`. The multiplier is reset by the same signal.

Cycle numbering, with `req` first sampled high at edge 0:
- `gnt` and `busy` high from cycle 1.
- `mm_enable_p` high in cycle 1 only.
- If `mm_done_irq_p` is sampled at edge k: `y` valid and `done_p` high in cycle k+1; `gnt` and `busy` low from cycle k+2.
- Earliest possible next grant: sampled at edge k+2.

Overhead: 3 cycles per operation beyond the multiplier's own latency.

Timeout: the ISSUE cycle is followed by exactly `TIMEOUT` WAIT cycles, then `err_p` pulses.

All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Benches use NBITS=8, NREQ=3, TIMEOUT=16, and a mock multiplier computing `(a*b) mod m` with a 5-cycle latency.

- **Single request**: `req=3'b010`, a=7, b=9, m=11 → `gnt=010`, one `mm_enable_p` pulse, `y=8`, `done_p=010` exactly once, `busy` low afterwards.
- **Simultaneous requests from reset**: `req=3'b111` held (each requester drops on its own `done_p`) → grants in order 0, 1, 2; three `done_p` pulses; no overlap of `gnt`.
- **Fairness**: requesters 0 and 2 held continuously (re-requesting) → grants alternate 0, 2, 0, 2; requester 1 joining is served within 2 operations.
- **Timeout**: mock never asserts done → `err_p` pulses exactly 17 cycles after `mm_enable_p`, `gnt` clears, `y` is unchanged from its prior value, and the next request proceeds normally.
- **Spurious done and operand change**: `mm_done_irq_p` pulsed in IDLE produces no `done_p`; `req_a` changed during WAIT leaves `mm_a` and the result unchanged.
- **Reset mid-WAIT**: `rst` asserted → all outputs are zero immediately, no pulses, and the first grant after release goes to requester 0.

Source files
------------

// File: rtl/mod_mul_arbiter.sv
// Round-robin arbiter that shares one Montgomery multiplier among NREQ requesters:
// latches the winner's operands, pulses start, waits for done (with a watchdog), returns y.
module mod_mul_arbiter #(
  parameter int NBITS   = 256,
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*NBITS-1:0] req_a,
  input  logic [NREQ*NBITS-1:0] req_b,
  input  logic [NREQ*NBITS-1:0] req_m,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done_p,
  output logic [NREQ-1:0]       err_p,
  output logic [NBITS-1:0]      y,
  output logic                  busy,
  output logic                  mm_enable_p,
  output logic [NBITS-1:0]      mm_a,
  output logic [NBITS-1:0]      mm_b,
  output logic [NBITS-1:0]      mm_m,
  input  logic [NBITS-1:0]      mm_y,
  input  logic                  mm_done_irq_p
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0] IDX_LAST = PW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] own;
  logic [PW-1:0] win;
  logic [CW-1:0] cnt;

  // Scan downward in offset so the requester closest to ptr (upward, wrapping) wins last.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
    logic [PW-1:0] w;
    int t;
    w = p;
    for (int k = NREQ - 1; k >= 0; k--) begin
      t = int'(p) + k;
      if (t >= NREQ) t = t - NREQ;
      if (r[t]) w = PW'(t);
    end
    return w;
  endfunction

  function automatic logic [NREQ-1:0] one_hot(input logic [PW-1:0] i);
    return NREQ'(1) << i;
  endfunction

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (i == IDX_LAST) ? '0 : i + 1'b1;
  endfunction

  always_comb win = rr_pick(req, ptr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      own         <= '0;
      cnt         <= '0;
      gnt         <= '0;
      done_p      <= '0;
      err_p       <= '0;
      busy        <= 1'b0;
      mm_enable_p <= 1'b0;
      y           <= '0;
      mm_a        <= '0;
      mm_b        <= '0;
      mm_m        <= '0;
    end else begin
      mm_enable_p <= 1'b0;
      done_p      <= '0;
      err_p       <= '0;
      case (state)
        IDLE: begin
          if (req != '0) begin
            mm_a        <= req_a[int'(win)*NBITS +: NBITS];
            mm_b        <= req_b[int'(win)*NBITS +: NBITS];
            mm_m        <= req_m[int'(win)*NBITS +: NBITS];
            gnt         <= one_hot(win);
            own         <= win;
            busy        <= 1'b1;
            mm_enable_p <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        // Done wins over a coincident watchdog expiry; y is only touched on a real completion.
        WAIT: begin
          if (mm_done_irq_p) begin
            y      <= mm_y;
            done_p <= one_hot(own);
            state  <= DONE;
          end else if (cnt == CNT_LAST) begin
            err_p <= one_hot(own);
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= next_idx(own);
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          gnt   <= '0;
          busy  <= 1'b0;
          ptr   <= next_idx(own);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
